kalman_sequencer: RTL and testbench

Sequencer that drives one Kalman update per accepted IMU sample. It runs the roll/pitch phase and then the yaw phase on the shared Kalman timer: it issues the timer's `timer_clear`, `roll_pitch_enable` and `yaw_enable` pulses and consumes its `kalman_done` flag. It emits latch strobes for the result registers and a valid/ready result handshake to the downstream consumer. A watchdog flags a timer that never completes.

---
 rtl/kalman_pkg.sv | 18 +
 rtl/kalman_sequencer_watchdog.sv | 34 +++
 rtl/kalman_sequencer.sv | 112 +++++++++++
 tb/tb_kalman_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/kalman_pkg.sv
// Shared types and constants for the Kalman update sequencer.
package kalman_pkg;

    localparam int DEFAULT_TIMEOUT_CYCLES = 100;

    typedef enum logic [3:0] {
        IDLE,
        RP_CLEAR,
        RP_START,
        RP_WAIT,
        YAW_CLEAR,
        YAW_START,
        YAW_WAIT,
        DONE,
        ERROR
    } seq_state_t;

endpackage

// File: rtl/kalman_sequencer_watchdog.sv
// Watchdog counter: zeroed by clear, counts while enabled, flags terminal count.
module watchdog_counter #(
    parameter int WD_BITS = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               enable,
    input  logic [WD_BITS-1:0] terminal,
    output logic               tc
);

    logic [WD_BITS-1:0] count_d, count_q;

    // Clear has priority over counting.
    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (enable)
            count_d = count_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign tc = (count_q == terminal);

endmodule

// File: rtl/kalman_sequencer.sv
// Sequences one roll/pitch + yaw Kalman update per accepted IMU sample,
// with a per-phase watchdog and a valid/ready result handshake.
module kalman_sequencer
    import kalman_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int WD_BITS        = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    output logic       sample_ready,
    input  logic       kalman_done,
    output logic       timer_clear,
    output logic       roll_pitch_enable,
    output logic       yaw_enable,
    output logic       rp_latch,
    output logic       yaw_latch,
    output logic       result_valid,
    input  logic       result_ready,
    output logic [7:0] frame_count,
    input  logic       err_clear,
    output logic       err
);

    localparam logic [WD_BITS-1:0] WD_TERM = WD_BITS'(TIMEOUT_CYCLES - 1);

    seq_state_t state_d, state_q;
    logic [7:0] frame_count_d, frame_count_q;
    logic       sample_ready_q, timer_clear_q, rp_enable_q, yaw_enable_q;
    logic       result_valid_q, err_q;
    logic       wd_tc;

    // Watchdog is zeroed in the START states and runs through the WAIT states.
    watchdog_counter #(.WD_BITS(WD_BITS)) u_wd (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q == RP_START || state_q == YAW_START),
        .enable   (state_q == RP_WAIT  || state_q == YAW_WAIT),
        .terminal (WD_TERM),
        .tc       (wd_tc)
    );

    // Next-state and frame counter; done beats a same-cycle timeout.
    always_comb begin
        state_d       = state_q;
        frame_count_d = frame_count_q;
        case (state_q)
            IDLE:      if (sample_valid) state_d = RP_CLEAR;
            RP_CLEAR:  state_d = RP_START;
            RP_START:  state_d = RP_WAIT;
            RP_WAIT: begin
                if (kalman_done)
                    state_d = YAW_CLEAR;
                else if (wd_tc)
                    state_d = ERROR;
            end
            YAW_CLEAR: state_d = YAW_START;
            YAW_START: state_d = YAW_WAIT;
            YAW_WAIT: begin
                if (kalman_done)
                    state_d = DONE;
                else if (wd_tc)
                    state_d = ERROR;
            end
            DONE: begin
                if (result_ready) begin
                    state_d       = IDLE;
                    frame_count_d = frame_count_q + 8'd1;
                end
            end
            ERROR:     if (err_clear) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // State register with Moore outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            frame_count_q  <= 8'd0;
            sample_ready_q <= 1'b1;
            timer_clear_q  <= 1'b0;
            rp_enable_q    <= 1'b0;
            yaw_enable_q   <= 1'b0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_count_q  <= frame_count_d;
            sample_ready_q <= (state_d == IDLE);
            timer_clear_q  <= (state_d == RP_CLEAR || state_d == YAW_CLEAR || state_d == ERROR);
            rp_enable_q    <= (state_d == RP_START);
            yaw_enable_q   <= (state_d == YAW_START);
            result_valid_q <= (state_d == DONE);
            err_q          <= (state_d == ERROR);
        end
    end

    assign sample_ready      = sample_ready_q;
    assign timer_clear       = timer_clear_q;
    assign roll_pitch_enable = rp_enable_q;
    assign yaw_enable        = yaw_enable_q;
    assign result_valid      = result_valid_q;
    assign err               = err_q;
    assign frame_count       = frame_count_q;

    // Latch strobes follow done in the same cycle so results are caught immediately.
    assign rp_latch  = (state_q == RP_WAIT)  && kalman_done;
    assign yaw_latch = (state_q == YAW_WAIT) && kalman_done;

endmodule

// File: tb/tb_kalman_sequencer.sv
// Directed bench for kalman_sequencer with a programmable-delay timer stub
// and a frame-count scoreboard.
module tb_kalman_sequencer;

    logic       clk = 1'b0;
    logic       rst, sample_valid, sample_ready, kalman_done, timer_clear;
    logic       roll_pitch_enable, yaw_enable, rp_latch, yaw_latch;
    logic       result_valid, result_ready, err_clear, err;
    logic [7:0] frame_count;

    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] exp_frame = 8'd0;
    logic [7:0] sb_q[$];

    // Timer stub: done rises on the stub_delay-th cycle counting the enable cycle as 1.
    int   stub_delay = 5;
    bit   stub_never = 1'b0;
    bit   force_done = 1'b0;
    int   st_cnt;
    logic st_run;

    always #5 clk = ~clk;

    kalman_sequencer #(.TIMEOUT_CYCLES(100), .WD_BITS(7)) dut (
        .clk               (clk),
        .rst               (rst),
        .sample_valid      (sample_valid),
        .sample_ready      (sample_ready),
        .kalman_done       (kalman_done),
        .timer_clear       (timer_clear),
        .roll_pitch_enable (roll_pitch_enable),
        .yaw_enable        (yaw_enable),
        .rp_latch          (rp_latch),
        .yaw_latch         (yaw_latch),
        .result_valid      (result_valid),
        .result_ready      (result_ready),
        .frame_count       (frame_count),
        .err_clear         (err_clear),
        .err               (err)
    );

    always @(posedge clk) begin
        if (rst || timer_clear) begin
            st_run <= 1'b0;
            st_cnt <= 0;
        end else if (roll_pitch_enable || yaw_enable) begin
            st_run <= 1'b1;
            st_cnt <= 2;
        end else if (st_run) begin
            st_cnt <= st_cnt + 1;
        end
    end

    assign kalman_done = force_done || (st_run && !stub_never && (st_cnt >= stub_delay));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] cur_vec();
        return {sample_ready, timer_clear, roll_pitch_enable, yaw_enable,
                rp_latch, yaw_latch, result_valid, err};
    endfunction

    // Expected outputs c cycles after accept, for a timer that completes in d cycles.
    function automatic logic [7:0] exp_vec(input int d, input int c);
        return {c == 0, (c == 1) || (c == d + 2), c == 2, c == d + 3,
                c == d + 1, c == 2 * d + 2, c >= 2 * d + 3, 1'b0};
    endfunction

    // One sample through both phases; optional consumer stall, stale done, or reset at abort_at.
    task automatic run_frame(input int d, input int stall, input bit stale, input int abort_at);
        stub_delay   = d;
        sample_valid = 1'b1;
        for (int c = 0; c <= 2 * d + 3; c++) begin
            force_done = stale && (c == 2);
            #1;
            check("frame_seq", 32'(cur_vec()), 32'(exp_vec(d, c)));
            if (c == 0) begin
                exp_frame = exp_frame + 8'd1;
                sb_q.push_back(exp_frame);
            end
            if (c == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                #1;
                check("rst_mid_vec", 32'(cur_vec()), 32'h80);
                check("rst_mid_frame", 32'(frame_count), 32'd0);
                void'(sb_q.pop_back());
                exp_frame = 8'd0;
                return;
            end
            if (c < 2 * d + 3) begin
                tick();
                sample_valid = 1'b0;
            end
        end
        for (int s = 0; s < stall; s++) begin
            tick();
            check("stall_vec", 32'(cur_vec()), 32'h02);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        #1;
        check("frame_count", 32'(frame_count), 32'(sb_q.pop_front()));
        check("ready_after_done", 32'(sample_ready), 32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        result_ready = 1'b0;
        err_clear    = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("reset_vec", 32'(cur_vec()), 32'h80);
        check("reset_frame", 32'(frame_count), 32'd0);

        run_frame(5, 0, 1'b0, -1);   // nominal, result_valid at cycle 13
        run_frame(5, 10, 1'b0, -1);  // stalled consumer
        run_frame(5, 0, 1'b1, -1);   // stale done during RP_START

        // Timer that never completes: err 100 cycles after RP_WAIT entry (cycle 3).
        stub_never   = 1'b1;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (101) tick();
        check("timeout_early", 32'(err), 32'd0);
        tick();
        check("timeout_err", 32'(err), 32'd1);
        repeat (5) tick();
        check("err_hold", 32'(err), 32'd1);
        check("err_ready_low", 32'(sample_ready), 32'd0);
        check("err_timer_clear", 32'(timer_clear), 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        #1;
        check("err_cleared", 32'(err), 32'd0);
        check("err_ready", 32'(sample_ready), 32'd1);
        check("err_frame", 32'(frame_count), 32'(exp_frame));
        stub_never = 1'b0;

        run_frame(101, 0, 1'b0, -1); // done on watchdog count 99 in both phases
        run_frame(3, 0, 1'b0, 7);    // reset in YAW_WAIT
        for (int f = 0; f < 256; f++)
            run_frame(2, 0, 1'b0, -1);
        check("wrap_final", 32'(frame_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
